preg_alloc_ctrl: RTL and testbench

Physical-register allocation controller for the rename stage. Holds the free physical-register IDs in a circular queue and grants up to two allocations per cycle to the dual decode/rename slots. Accepts up to two frees per cycle from commit. Checkpoints the allocation pointer per branch tag and rolls it back on a branch shootdown.

---
 rtl/preg_alloc_if.sv | 38 +++
 rtl/preg_alloc_ctrl.sv | 78 +++++++
 tb/tb_preg_alloc_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/preg_alloc_if.sv
// Rename/commit side of the physical-register allocator: allocation requests,
// returned pregs, and branch checkpoint/shootdown controls.
interface preg_alloc_if #(
  parameter int NUM_PREGS         = 64,
  parameter int MAX_PREDICT_DEPTH = 4
);
  localparam int P                      = $clog2(NUM_PREGS);
  localparam int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);

  // Allocation is a same-cycle request/grant: alloc_req (0..2) acts as valid,
  // alloc_grant as ready; the pregs transfer on the edge where both are high.
  // Frees, checkpoints and shootdowns are valid-only and can never be refused.
  logic [1:0]                        alloc_req;
  logic                              alloc_grant;
  logic [P-1:0]                      alloc_preg1;
  logic [P-1:0]                      alloc_preg2;
  logic [P:0]                        num_free;
  logic                              free_valid1;
  logic                              free_valid2;
  logic [P-1:0]                      free_preg1;
  logic [P-1:0]                      free_preg2;
  logic                              checkpoint_valid;
  logic [MAX_PREDICT_DEPTH_BITS-1:0] checkpoint_tag;
  logic                              branch_shootdown;
  logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_tag;

  modport master (
    output alloc_req, free_valid1, free_valid2, free_preg1, free_preg2,
           checkpoint_valid, checkpoint_tag, branch_shootdown, shootdown_tag,
    input  alloc_grant, alloc_preg1, alloc_preg2, num_free
  );

  modport slave (
    input  alloc_req, free_valid1, free_valid2, free_preg1, free_preg2,
           checkpoint_valid, checkpoint_tag, branch_shootdown, shootdown_tag,
    output alloc_grant, alloc_preg1, alloc_preg2, num_free
  );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// Free-list controller: circular queue of free preg IDs, two grants and two
// frees per cycle, with per-branch-tag checkpoints of the allocation pointer.
module preg_alloc_ctrl #(
  parameter int NUM_PREGS         = 64,
  parameter int NUM_ARCH_REGS     = 32,
  parameter int MAX_PREDICT_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  preg_alloc_if.slave bus
);
  localparam int P          = $clog2(NUM_PREGS);
  localparam int INIT_FREE  = NUM_PREGS - NUM_ARCH_REGS;

  logic [P-1:0] q    [NUM_PREGS];
  logic [P:0]   ckpt [MAX_PREDICT_DEPTH];
  logic [P:0]   head;
  logic [P:0]   tail;

  logic [P:0]   num_free_w;
  logic [P:0]   head_alloc;
  logic         grant;
  logic [1:0]   grant_cnt;
  logic [1:0]   free_cnt;
  logic [P-1:0] head_idx;
  logic [P-1:0] head_idx2;
  logic [P-1:0] wr_idx1;
  logic [P-1:0] wr_idx2;

  always_comb begin
    num_free_w = tail - head;
    grant      = !reset && !bus.branch_shootdown && (bus.alloc_req != 2'd0) &&
                 (num_free_w >= (P+1)'(bus.alloc_req));
    grant_cnt  = grant ? bus.alloc_req : 2'd0;
    head_alloc = head + (P+1)'(grant_cnt);
    head_idx   = head[P-1:0];
    head_idx2  = head[P-1:0] + P'(1);
    free_cnt   = {1'b0, bus.free_valid1} + {1'b0, bus.free_valid2};
    wr_idx1    = tail[P-1:0];
    // A lone slot-2 free takes the tail slot itself.
    wr_idx2    = bus.free_valid1 ? (tail[P-1:0] + P'(1)) : tail[P-1:0];
  end

  assign bus.alloc_grant = grant;
  assign bus.alloc_preg1 = q[head_idx];
  assign bus.alloc_preg2 = q[head_idx2];
  assign bus.num_free    = num_free_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        q[i] <= (i < INIT_FREE) ? P'(NUM_ARCH_REGS + i) : '0;
      end
      for (int i = 0; i < MAX_PREDICT_DEPTH; i++) begin
        ckpt[i] <= '0;
      end
      head <= '0;
      tail <= (P+1)'(INIT_FREE);
    end else begin
      if (bus.free_valid1) q[wr_idx1] <= bus.free_preg1;
      if (bus.free_valid2) q[wr_idx2] <= bus.free_preg2;
      tail <= tail + (P+1)'(free_cnt);
      // Shootdown wins over this cycle's grant and checkpoint; frees still land.
      if (bus.branch_shootdown) begin
        head <= ckpt[bus.shootdown_tag];
      end else begin
        head <= head_alloc;
        if (bus.checkpoint_valid) ckpt[bus.checkpoint_tag] <= head_alloc;
      end
    end
  end

  a_no_req3: assert property (@(posedge clk) disable iff (reset)
    bus.alloc_req != 2'd3);

  a_no_overfree: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, num_free_w} + (P+2)'(free_cnt)) <= (P+2)'(NUM_PREGS));
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Bench for preg_alloc_ctrl: directed walk-throughs of the allocation, free and
// rollback scenarios, then random traffic against a free-list/held-list model.
module tb_preg_alloc_ctrl;
  localparam int NP = 64;
  localparam int NA = 32;
  localparam int ND = 4;
  localparam int P  = 6;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  preg_alloc_if #(.NUM_PREGS(NP), .MAX_PREDICT_DEPTH(ND)) bus();

  preg_alloc_ctrl #(.NUM_PREGS(NP), .NUM_ARCH_REGS(NA), .MAX_PREDICT_DEPTH(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] req,
                       input logic fv1, input logic [P-1:0] fp1,
                       input logic fv2, input logic [P-1:0] fp2,
                       input logic cv, input logic [1:0] ct,
                       input logic sd, input logic [1:0] st);
    bus.alloc_req        = req;
    bus.free_valid1      = fv1;
    bus.free_preg1       = fp1;
    bus.free_valid2      = fv2;
    bus.free_preg2       = fp2;
    bus.checkpoint_valid = cv;
    bus.checkpoint_tag   = ct;
    bus.branch_shootdown = sd;
    bus.shootdown_tag    = st;
  endtask

  task automatic req_only(input logic [1:0] req);
    drive(req, 1'b0, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_only(2'd2);
    @(negedge clk);
    check("grant_in_reset", {31'b0, bus.alloc_grant}, 32'd0);
    next_cycle();
    reset = 1'b0;
  endtask

  // reference model: free list, pregs held by in-flight instructions with the
  // allocation position they were taken at, and checkpointed positions
  typedef struct packed { int preg; int pos; } held_t;
  int    free_q[$];
  held_t held[$];
  int    pos;
  int    ck_pos   [ND];
  bit    ck_valid [ND];

  task automatic model_reset();
    free_q.delete();
    held.delete();
    for (int i = NA; i < NP; i++) free_q.push_back(i);
    pos = 0;
    for (int t = 0; t < ND; t++) begin
      ck_pos[t]   = 0;
      ck_valid[t] = 1'b0;
    end
  endtask

  task automatic random_cycle();
    logic [1:0]   req, ct, st;
    logic         sd, cv, fv1, fv2;
    logic [P-1:0] fp1, fp2;
    int           min_ck, nok, nfree, c, t;
    bit           exp_grant;
    held_t        h;

    sd = 1'b0;
    st = 2'd0;
    t  = $urandom_range(0, ND-1);
    if (($urandom % 10) == 0 && ck_valid[t]) begin
      sd = 1'b1;
      st = 2'(t);
    end
    req = 2'($urandom_range(0, 2));
    cv  = (($urandom % 4) == 0);
    ct  = 2'($urandom_range(0, ND-1));

    // commit only returns pregs older than every live checkpoint
    min_ck = 32'h7fffffff;
    for (int k = 0; k < ND; k++) if (ck_valid[k] && ck_pos[k] < min_ck) min_ck = ck_pos[k];
    nok = 0;
    if (held.size() > 0 && held[0].pos < min_ck) nok = 1;
    if (nok == 1 && held.size() > 1 && held[1].pos < min_ck) nok = 2;
    nfree = $urandom_range(0, nok);
    fv1 = 1'b0; fv2 = 1'b0; fp1 = '0; fp2 = '0;
    if (nfree == 2) begin
      h = held.pop_front(); fv1 = 1'b1; fp1 = P'(h.preg);
      h = held.pop_front(); fv2 = 1'b1; fp2 = P'(h.preg);
    end else if (nfree == 1) begin
      h = held.pop_front();
      if ($urandom % 2) begin fv1 = 1'b1; fp1 = P'(h.preg); end
      else              begin fv2 = 1'b1; fp2 = P'(h.preg); end
    end

    drive(req, fv1, fp1, fv2, fp2, cv, ct, sd, st);
    @(negedge clk);
    exp_grant = !sd && req != 2'd0 && free_q.size() >= int'(req);
    check("rnd_num_free", 32'(bus.num_free), 32'(free_q.size()));
    check("rnd_grant", {31'b0, bus.alloc_grant}, {31'b0, exp_grant});
    if (exp_grant) check("rnd_preg1", 32'(bus.alloc_preg1), 32'(free_q[0]));
    if (exp_grant && req == 2'd2) check("rnd_preg2", 32'(bus.alloc_preg2), 32'(free_q[1]));

    if (sd) begin
      c = ck_pos[st];
      while (held.size() > 0 && held[$].pos >= c) begin
        h = held.pop_back();
        free_q.push_front(h.preg);
      end
      pos = c;
      for (int k = 0; k < ND; k++) if (ck_pos[k] > c) ck_valid[k] = 1'b0;
    end else begin
      if (exp_grant) begin
        for (int j = 0; j < int'(req); j++) begin
          h.preg = free_q.pop_front();
          h.pos  = pos;
          held.push_back(h);
          pos++;
        end
      end
      if (cv) begin
        ck_pos[ct]   = pos;
        ck_valid[ct] = 1'b1;
      end
    end
    if (fv1) free_q.push_back(int'(fp1));
    if (fv2) free_q.push_back(int'(fp2));
    // a correctly predicted branch retires its checkpoint
    if (($urandom % 6) == 0) ck_valid[$urandom_range(0, ND-1)] = 1'b0;
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req_only(2'd0);
    next_cycle();

    // back-to-back double allocations drain the initial free list
    do_reset();
    for (int k = 0; k < 16; k++) begin
      req_only(2'd2);
      @(negedge clk);
      check("drain_num_free", 32'(bus.num_free), 32'(32 - 2*k));
      check("drain_grant", {31'b0, bus.alloc_grant}, 32'd1);
      check("drain_preg1", 32'(bus.alloc_preg1), 32'(32 + 2*k));
      check("drain_preg2", 32'(bus.alloc_preg2), 32'(33 + 2*k));
      next_cycle();
    end
    req_only(2'd2);
    @(negedge clk);
    check("empty_num_free", 32'(bus.num_free), 32'd0);
    check("empty_grant", {31'b0, bus.alloc_grant}, 32'd0);
    next_cycle();

    // all-or-nothing grant, then frees arriving on an empty queue
    do_reset();
    for (int k = 0; k < 15; k++) begin req_only(2'd2); next_cycle(); end
    req_only(2'd1);
    next_cycle();
    req_only(2'd2);
    @(negedge clk);
    check("one_left_num_free", 32'(bus.num_free), 32'd1);
    check("one_left_req2_grant", {31'b0, bus.alloc_grant}, 32'd0);
    next_cycle();
    req_only(2'd1);
    @(negedge clk);
    check("one_left_head_kept", 32'(bus.num_free), 32'd1);
    check("one_left_req1_grant", {31'b0, bus.alloc_grant}, 32'd1);
    check("one_left_preg1", 32'(bus.alloc_preg1), 32'd63);
    next_cycle();
    drive(2'd1, 1'b1, 6'd5, 1'b1, 6'd7, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("free_no_bypass_num_free", 32'(bus.num_free), 32'd0);
    check("free_no_bypass_grant", {31'b0, bus.alloc_grant}, 32'd0);
    next_cycle();
    req_only(2'd2);
    @(negedge clk);
    check("freed_num_free", 32'(bus.num_free), 32'd2);
    check("freed_grant", {31'b0, bus.alloc_grant}, 32'd1);
    check("freed_preg1", 32'(bus.alloc_preg1), 32'd5);
    check("freed_preg2", 32'(bus.alloc_preg2), 32'd7);
    next_cycle();
    drive(2'd0, 1'b0, '0, 1'b1, 6'd9, 1'b0, 2'd0, 1'b0, 2'd0);
    next_cycle();
    req_only(2'd1);
    @(negedge clk);
    check("lone_free2_num_free", 32'(bus.num_free), 32'd1);
    check("lone_free2_preg1", 32'(bus.alloc_preg1), 32'd9);
    next_cycle();

    // checkpoint with allocation, rollback, and rollback racing checkpoint + frees
    do_reset();
    drive(2'd2, 1'b0, '0, 1'b0, '0, 1'b1, 2'd2, 1'b0, 2'd0);
    @(negedge clk);
    check("ckpt_grant", {31'b0, bus.alloc_grant}, 32'd1);
    next_cycle();
    req_only(2'd2); next_cycle();
    req_only(2'd2); next_cycle();
    drive(2'd2, 1'b0, '0, 1'b0, '0, 1'b0, 2'd0, 1'b1, 2'd2);
    @(negedge clk);
    check("sd_grant_dropped", {31'b0, bus.alloc_grant}, 32'd0);
    check("sd_num_free_before", 32'(bus.num_free), 32'd26);
    next_cycle();
    req_only(2'd2);
    @(negedge clk);
    check("sd_num_free_after", 32'(bus.num_free), 32'd30);
    check("sd_preg1", 32'(bus.alloc_preg1), 32'd34);
    check("sd_preg2", 32'(bus.alloc_preg2), 32'd35);
    next_cycle();
    drive(2'd2, 1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 2'd1, 1'b1, 2'd2);
    @(negedge clk);
    check("race_grant_dropped", {31'b0, bus.alloc_grant}, 32'd0);
    next_cycle();
    req_only(2'd0);
    @(negedge clk);
    check("race_num_free", 32'(bus.num_free), 32'd32);
    next_cycle();
    drive(2'd0, 1'b0, '0, 1'b0, '0, 1'b0, 2'd0, 1'b1, 2'd1);
    next_cycle();
    req_only(2'd2);
    @(negedge clk);
    check("unwritten_ckpt_num_free", 32'(bus.num_free), 32'd34);
    check("unwritten_ckpt_preg1", 32'(bus.alloc_preg1), 32'd32);
    next_cycle();
    for (int k = 0; k < 15; k++) begin req_only(2'd2); next_cycle(); end
    req_only(2'd2);
    @(negedge clk);
    check("race_freed_preg1", 32'(bus.alloc_preg1), 32'd1);
    check("race_freed_preg2", 32'(bus.alloc_preg2), 32'd2);
    next_cycle();

    // random traffic; pointers wrap many times over the run
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) random_cycle();

    req_only(2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
